// File: rtl/seq_detector_param.sv
// seq_detector_param: parametrised serial pattern detector (KMP-style fallback).
// State k counts pattern bits matched so far; mismatches fall back through the
// elaboration-time failure table so partial overlaps are never lost.
// Optional feature macro: SEQ_DET_REG_OUT_EN (registered data_out, 1-cycle later).
module seq_detector_param #(
    parameter int                  PAT_LEN = 4,
    parameter logic [PAT_LEN-1:0]  PATTERN = 4'b1010,
    parameter int                  CNT_W   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             valid_in,
    input  logic             data_in,
    input  logic             overlap_en,
    output logic             data_out,
    output logic [CNT_W-1:0] match_count
);

    localparam int SW = $clog2(PAT_LEN);      // state register width
    localparam int IW = $clog2(PAT_LEN + 1);  // index width covering 0..PAT_LEN

    typedef logic [PAT_LEN:0][IW-1:0] fail_t;

    // Pattern in arrival order: bit i is the i-th bit received. Top bit is padding
    // so that IW-bit indices select it without width mismatch.
    function automatic logic [PAT_LEN:0] rev_pat();
        logic [PAT_LEN:0]   r;
        logic [PAT_LEN-1:0] p;
        r = '0;
        p = PATTERN;
        repeat (PAT_LEN) begin
            r = {r[PAT_LEN-1:0], p[0]};
            p = p >> 1;
        end
        return r;
    endfunction

    // Failure function: f[k] = longest proper prefix that is also a suffix of
    // the first k pattern bits.
    function automatic fail_t calc_fail(input logic [PAT_LEN:0] s);
        fail_t          f;
        logic [IW-1:0]  j;
        f = '0;
        for (logic [IW-1:0] i = IW'(1); i < IW'(PAT_LEN); i = i + IW'(1)) begin
            j = f[i];
            while (j != '0 && s[j] != s[i])
                j = f[j];
            if (s[j] == s[i])
                j = j + IW'(1);
            f[i + IW'(1)] = j;
        end
        return f;
    endfunction

    localparam logic [PAT_LEN:0] PAT_S = rev_pat();
    localparam fail_t            FAIL_T = calc_fail(PAT_S);

    logic [SW-1:0]    k_q, k_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             hit;

    // Next state: advance on expected bit, otherwise walk the fallback chain once.
    always_comb begin
        logic [IW-1:0] j;
        logic [IW-1:0] nxt;
        j   = IW'(k_q);
        nxt = j;
        hit = 1'b0;
        if (valid_in) begin
            if (PAT_S[j] == data_in) begin
                if (j == IW'(PAT_LEN - 1)) begin
                    hit = 1'b1;
                    nxt = overlap_en ? FAIL_T[IW'(PAT_LEN)] : '0;
                end else begin
                    nxt = j + IW'(1);
                end
            end else begin
                for (int i = 0; i < PAT_LEN; i++) begin
                    if (j != '0 && PAT_S[j] != data_in)
                        j = FAIL_T[j];
                end
                // A fallback target is always below PAT_LEN-1, so no match here.
                nxt = (PAT_S[j] == data_in) ? j + IW'(1) : '0;
            end
        end
        k_d = SW'(nxt);
    end

    // Saturating match counter next value.
    always_comb begin
        cnt_d = cnt_q;
        if (hit && cnt_q != '1)
            cnt_d = cnt_q + CNT_W'(1);
    end

    // State and counter registers; reset overrides any simultaneous match.
    always_ff @(posedge clk) begin
        if (rst) begin
            k_q   <= '0;
            cnt_q <= '0;
        end else begin
            k_q   <= k_d;
            cnt_q <= cnt_d;
        end
    end

    assign match_count = cnt_q;

`ifdef SEQ_DET_REG_OUT_EN
    logic dout_q;

    // Registered match pulse, one cycle after the final bit.
    always_ff @(posedge clk) begin
        if (rst)
            dout_q <= 1'b0;
        else
            dout_q <= hit;
    end

    assign data_out = dout_q;
`else
    assign data_out = hit & ~rst;
`endif

endmodule
